// File: rtl/wb_arbiter.sv
// Two-master / one-slave Wishbone B4 classic arbiter with round-robin tie-break,
// whole-cycle grant hold and a strobe watchdog that errors out hung slave accesses.
module wb_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i
);
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic [WW-1:0] wdt_q, wdt_d;
    logic          busy, gcyc, expire, gack, gerr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            wdt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            wdt_q   <= wdt_d;
        end
    end

    assign busy = (state_q == BUSY);
    assign gcyc = gnt_q ? m1_cyc_i : m0_cyc_i;

    // Slave side only sees the granted master, and only while a cycle is owned.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        if (busy) begin
            if (gnt_q) begin
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i;
                s_we_o  = m1_we_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_sel_o = m1_sel_i;
            end else begin
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i;
                s_we_o  = m0_we_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_sel_o = m0_sel_i;
            end
        end
    end

    // A genuine slave response in the expiry cycle suppresses the forced error.
    assign expire = (TIMEOUT > 0) && busy && s_stb_o && (wdt_q == WW'(TIMEOUT))
                    && !s_ack_i && !s_err_i;
    assign gack   = busy && s_ack_i && !s_err_i;
    assign gerr   = busy && (s_err_i || expire);

    assign m0_ack_o = gack && !gnt_q;
    assign m0_err_o = gerr && !gnt_q;
    assign m1_ack_o = gack && gnt_q;
    assign m1_err_o = gerr && gnt_q;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        wdt_d   = wdt_q;
        case (state_q)
            IDLE: begin
                wdt_d = '0;
                if (m0_cyc_i || m1_cyc_i) begin
                    gnt_d   = (m0_cyc_i && m1_cyc_i) ? ~last_q : m1_cyc_i;
                    last_d  = gnt_d;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!gcyc) begin
                    state_d = IDLE;
                    wdt_d   = '0;
                end else if (TIMEOUT == 0 || !s_stb_o || s_ack_i || s_err_i || expire) begin
                    wdt_d = '0;
                end else begin
                    wdt_d = wdt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, single read, round-robin, grant hold,
// watchdog expiry and error routing, with hand-computed expectations.
module tb_wb_arbiter;
    localparam logic [31:0] A0 = 32'h0000_0A00;
    localparam logic [31:0] A1 = 32'h0000_0B10;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
    logic [31:0] m0_adr_i = '0, m0_dat_i = '0;
    logic [3:0]  m0_sel_i = '0;
    logic [31:0] m0_dat_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
    logic [31:0] m1_adr_i = '0, m1_dat_i = '0;
    logic [3:0]  m1_sel_i = '0;
    logic [31:0] m1_dat_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_i = '0;
    logic        s_ack_i = 0, s_err_i = 0;

    int n_cmp = 0;
    int n_bad = 0;

    wb_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL time_limit: got no finish, want finish before 200000");
        $fatal(1);
    end

    task automatic test_reset();
        logic [75:0] outs;
        #3;
        outs = {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
                m0_ack_o, m0_err_o, m1_ack_o, m1_err_o};
        n_cmp++;
        if (outs !== '0) begin n_bad++; $display("FAIL rst_outs: got %h want 0", outs); end
        // m1 gets the bus, then reset lands mid-transaction
        @(posedge clk_i); #1;
        rst_i = 0; m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = A1;
        @(posedge clk_i); #1;
        n_cmp++;
        if (s_cyc_o !== 1'b1 || s_adr_o !== A1) begin
            n_bad++; $display("FAIL rst_m1_gnt: got cyc=%b adr=%h want 1 %h", s_cyc_o, s_adr_o, A1);
        end
        #2; rst_i = 1; #1;
        n_cmp++;
        if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
            n_bad++; $display("FAIL rst_async_drop: got cyc=%b stb=%b want 0 0", s_cyc_o, s_stb_o);
        end
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = A0;
        @(posedge clk_i); #1;
        rst_i = 0; #1;
        n_cmp++;
        if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL rst_release_idle: got %b want 0", s_cyc_o); end
        @(posedge clk_i); #1;
        n_cmp++;
        if (s_cyc_o !== 1'b1 || s_adr_o !== A0) begin
            n_bad++; $display("FAIL rst_first_tie_m0: got cyc=%b adr=%h want 1 %h", s_cyc_o, s_adr_o, A0);
        end
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        @(posedge clk_i); #1;
        n_cmp++;
        if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL rst_release_bus: got %b want 0", s_cyc_o); end
    endtask

    task automatic test_single_read();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'h100; m0_sel_i = 4'hF;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk_i); #1;
            s_ack_i = (c == 3);
            s_dat_i = (c == 3) ? 32'hDEAD_BEEF : 32'h0;
            #1;
            n_cmp++;
            if (m0_ack_o !== (c == 3) || m1_ack_o !== 1'b0) begin
                n_bad++; $display("FAIL rd_ack_c%0d: got m0=%b m1=%b want %b 0", c, m0_ack_o, m1_ack_o, c == 3);
            end
            if (c == 1) begin
                n_cmp++;
                if (s_cyc_o !== 1'b1 || s_adr_o !== 32'h100 || s_sel_o !== 4'hF) begin
                    n_bad++; $display("FAIL rd_bus: got cyc=%b adr=%h sel=%h want 1 100 f", s_cyc_o, s_adr_o, s_sel_o);
                end
            end
            if (c == 3) begin
                n_cmp++;
                if (m0_dat_o !== 32'hDEAD_BEEF) begin
                    n_bad++; $display("FAIL rd_data: got %h want deadbeef", m0_dat_o);
                end
            end
        end
        @(posedge clk_i); #1;
        m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0; s_dat_i = '0; #1;
        n_cmp++;
        if (s_cyc_o !== 1'b0 || m1_ack_o !== 1'b0) begin
            n_bad++; $display("FAIL rd_release: got cyc=%b m1ack=%b want 0 0", s_cyc_o, m1_ack_o);
        end
        @(posedge clk_i); #1;
    endtask

    // Last owner so far is m0, so the first contended grant goes to m1.
    task automatic test_round_robin();
        logic owner;
        owner = 1'b1;
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = A0;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = A1;
        s_ack_i = 1;
        for (int t = 0; t < 4; t++) begin
            @(posedge clk_i); #2;
            n_cmp++;
            if (s_cyc_o !== 1'b1 || s_adr_o !== (owner ? A1 : A0)
                || m0_ack_o !== !owner || m1_ack_o !== owner) begin
                n_bad++;
                $display("FAIL rr_owner_%0d: got cyc=%b adr=%h ack0=%b ack1=%b want owner m%0d",
                         t, s_cyc_o, s_adr_o, m0_ack_o, m1_ack_o, owner);
            end
            @(posedge clk_i); #1;
            if (owner) begin m1_cyc_i = 0; m1_stb_i = 0; end
            else begin m0_cyc_i = 0; m0_stb_i = 0; end
            #1;
            n_cmp++;
            if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL rr_drop_%0d: got %b want 0", t, s_cyc_o); end
            @(posedge clk_i); #1;
            m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; #1;
            n_cmp++;
            if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL rr_idle_%0d: got %b want 0", t, s_cyc_o); end
            owner = ~owner;
        end
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
        @(posedge clk_i); #1;
    endtask

    // Last owner is m0, so m1 wins the tie and keeps the bus over 3 beats.
    task automatic test_grant_hold();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        @(posedge clk_i); #1;
        for (int b = 0; b < 3; b++) begin
            m1_stb_i = 1; s_ack_i = 1; #1;
            n_cmp++;
            if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 || s_adr_o !== A1
                || m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin
                n_bad++;
                $display("FAIL hold_beat_%0d: got cyc=%b stb=%b adr=%h ack1=%b ack0=%b want 1 1 %h 1 0",
                         b, s_cyc_o, s_stb_o, s_adr_o, m1_ack_o, m0_ack_o, A1);
            end
            @(posedge clk_i); #1;
            m1_stb_i = 0; s_ack_i = 0; #1;
            n_cmp++;
            if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b0 || s_adr_o !== A1) begin
                n_bad++; $display("FAIL hold_gap_%0d: got cyc=%b stb=%b adr=%h want 1 0 %h",
                                  b, s_cyc_o, s_stb_o, s_adr_o, A1);
            end
            @(posedge clk_i); #1;
        end
        m1_cyc_i = 0; #1;
        n_cmp++;
        if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL hold_m1_drop: got %b want 0", s_cyc_o); end
        @(posedge clk_i); #2;
        n_cmp++;
        if (s_cyc_o !== 1'b0) begin n_bad++; $display("FAIL hold_idle: got %b want 0", s_cyc_o); end
        @(posedge clk_i); #2;
        n_cmp++;
        if (s_cyc_o !== 1'b1 || s_adr_o !== A0) begin
            n_bad++; $display("FAIL hold_m0_next: got cyc=%b adr=%h want 1 %h", s_cyc_o, s_adr_o, A0);
        end
        @(posedge clk_i); #1;
        m0_cyc_i = 0; m0_stb_i = 0;
        @(posedge clk_i); #1;
    endtask

    // TIMEOUT=4: forced err in 5th strobe cycle, counter restarts, then a real
    // ack in the next expiry cycle suppresses the forced err.
    task automatic test_timeout();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = A0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk_i); #1;
            s_ack_i = (c == 10); #1;
            n_cmp++;
            if (m0_err_o !== (c == 5) || m0_ack_o !== (c == 10) || m1_err_o !== 1'b0) begin
                n_bad++;
                $display("FAIL wdt_c%0d: got err=%b ack=%b err1=%b want %b %b 0",
                         c, m0_err_o, m0_ack_o, m1_err_o, c == 5, c == 10);
            end
        end
        @(posedge clk_i); #1;
        m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_err_path();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = A1;
        m1_dat_i = 32'h1234_5678; m1_sel_i = 4'h3;
        @(posedge clk_i); #1;
        s_err_i = 1; s_ack_i = 1; #1;
        n_cmp++;
        if (m1_err_o !== 1'b1 || m1_ack_o !== 1'b0) begin
            n_bad++; $display("FAIL err_m1: got err=%b ack=%b want 1 0", m1_err_o, m1_ack_o);
        end
        n_cmp++;
        if (m0_err_o !== 1'b0 || m0_ack_o !== 1'b0) begin
            n_bad++; $display("FAIL err_m0_clean: got err=%b ack=%b want 0 0", m0_err_o, m0_ack_o);
        end
        n_cmp++;
        if (s_we_o !== 1'b1 || s_dat_o !== 32'h1234_5678 || s_sel_o !== 4'h3) begin
            n_bad++; $display("FAIL err_wr_bus: got we=%b dat=%h sel=%h want 1 12345678 3",
                              s_we_o, s_dat_o, s_sel_o);
        end
        @(posedge clk_i); #1;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; s_err_i = 0; s_ack_i = 0;
        @(posedge clk_i); #1;
        n_cmp++;
        if (s_cyc_o !== 1'b0 || m1_err_o !== 1'b0) begin
            n_bad++; $display("FAIL err_release: got cyc=%b err=%b want 0 0", s_cyc_o, m1_err_o);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_grant_hold();
        test_timeout();
        test_err_path();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
